multi_queue_scheduler: RTL and testbench
========================================

Name: multi_queue_scheduler

Overview:
- Parametrised successor to the fixed four-buffer, six-slot packet reader: N independent FIFO channels of depth DEPTH, each entry DATA_W wide.
- A built-in tick divider sets the service rate. On each service tick, one entry is dequeued from one channel.
- The channel is chosen by latency, reliability or auto mode.
- Sits between the per-channel packet sources and the display/output stage. Replaces the external frequency divider and the validity-bit-encoded buffers.

Parameters:
- N_CH, 4, number of channels (>=2)
- DEPTH, 6, entries per channel FIFO (>=2)
- DATA_W, 2, payload width per entry
- TICK_DIV, 4, clock cycles per service tick (>=1; 1 = every cycle)
- THRESH, 3, auto-mode occupancy threshold

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- push_valid  in  N_CH  per-channel write strobe
- push_data  in  N_CH*DATA_W  per-channel write data; channel k at [k*DATA_W +: DATA_W]
- push_ready  out  N_CH  channel k not full
- mode_sel  in  2  00 latency, 01 reliability, 10/11 auto
- out_valid  out  1  one-cycle pulse: out_data/out_chan valid
- out_data  out  DATA_W  dequeued payload
- out_chan  out  CW  source channel of out_data; CW = $clog2(N_CH)
- mode_active  out  1  mode used at last tick: 0 latency, 1 reliability
- occupancy  out  N_CH*OW  per-channel entry count; OW = $clog2(DEPTH+1)
- drop_cnt  out  8  saturating count of rejected pushes

Behaviour:
- Clock is clk; rst is synchronous and active-high. Single clock domain.
- Reset (rst=1 at posedge):
  - all FIFOs empty, so occupancy=0 and push_ready all 1
  - out_valid=0, out_data=0, out_chan=0, mode_active=0, drop_cnt=0
  - tick counter=0
  - round-robin pointer=N_CH-1, so the first RR search starts at channel 0
  - rst mid-operation discards all queued data. No output pulse in the reset cycle or the cycle after.
- Push:
  - Channel k accepts when push_valid[k] && push_ready[k]. Data is written at the tail and occupancy increments at the next edge.
  - push_valid[k] with channel k full: data discarded, drop_cnt += 1 per rejected channel per cycle, saturating at 255.
  - Multiple channels may push in the same cycle.
- Tick:
  - The counter counts 0..TICK_DIV-1 and wraps. tick is asserted in the cycle the counter equals TICK_DIV-1.
  - The first tick occurs in the TICK_DIV-th cycle after rst deasserts.
- Selection (combinational, evaluated in the tick cycle on registered occupancies, before that cycle's pushes):
  - Auto mode: latency if max occupancy >= THRESH, else reliability.
  - Latency mode: the channel with the largest occupancy. Ties go to the lowest index.
  - Reliability mode: the first non-empty channel after the RR pointer, searching upward with wrap to 0.
  - All channels empty at tick: no dequeue. out_valid stays 0. mode_active and the RR pointer are unchanged.
- Dequeue (tick and a channel is granted):
  - Head of the granted channel is read and its occupancy decrements.
  - RR pointer := granted channel, in both modes.
  - mode_active is updated.
  - In the next cycle: out_valid=1, out_data=head entry, out_chan=granted index.
  - Latency from tick to out_valid is 1 cycle. out_data and out_chan hold until the next grant. out_valid is high for exactly 1 cycle.
- Simultaneous push and pop on the same channel: both happen and occupancy is unchanged.
  - A full channel cannot accept a push in the same cycle it is popped, because push_ready reflects the registered state.
  - A push to an empty channel is not eligible for the tick in that same cycle.
- Wrap-around:
  - FIFO read/write pointers wrap modulo DEPTH. DEPTH need not be a power of 2.
  - Order within a channel is strict FIFO.

Test Plan:
- Defaults; rst, then push 0b01,0b10,0b11 to ch2 and 0b01 to ch0; mode_sel=00 -> first out_valid at cycle TICK_DIV+1 after the pushes settle, out_chan=2 and out_data=01; the next tick also gives ch2 (occ 2 vs 1 ties to ch0? No: 2>1, so ch2, data 10).
- Latency tie: ch1 and ch3 each hold 2 entries, mode_sel=00 -> out_chan=1 on first tick; then ch3 (occ 2 > 1) on the next tick.
- Reliability RR: one entry each in ch0..ch3, mode_sel=01 -> out_chan sequence 0,1,2,3; mode_active=1; then all empty, so no further out_valid.
- Auto: ch1 occupancy 2, ch3 occupancy 1, mode_sel=10 -> reliability, ch1 served, mode_active=1; fill ch2 to 3 -> next tick is latency, out_chan=2, mode_active=0.
- Overflow: 8 consecutive pushes to ch0 with no tick (TICK_DIV=64) -> push_ready[0]=0 after 6; drop_cnt=2; the 6 dequeued values appear in push order.
- Reset mid-stream: rst while ch0 holds 4 entries and a tick is pending -> no out_valid; occupancy=0; drop_cnt=0; after release, first tick lands TICK_DIV cycles later.

Source files
------------

// File: rtl/multi_queue_scheduler.sv
// Multi-channel FIFO scheduler: N_CH independent queues drained one entry per
// service tick, choosing the channel by occupancy (latency), round-robin
// (reliability) or an occupancy-threshold blend of the two (auto).
module multi_queue_scheduler #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned DEPTH    = 6,
  parameter int unsigned DATA_W   = 2,
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned THRESH   = 3,
  localparam int unsigned CW      = $clog2(N_CH),
  localparam int unsigned OW      = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        push_valid,
  input  logic [N_CH*DATA_W-1:0] push_data,
  output logic [N_CH-1:0]        push_ready,
  input  logic [1:0]             mode_sel,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [CW-1:0]          out_chan,
  output logic                   mode_active,
  output logic [N_CH*OW-1:0]     occupancy,
  output logic [7:0]             drop_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [DATA_W-1:0] mem_q [N_CH][DEPTH];

  logic [OW-1:0] occ_q    [N_CH];
  logic [OW-1:0] occ_d    [N_CH];
  logic [PW-1:0] rd_ptr_q [N_CH];
  logic [PW-1:0] rd_ptr_d [N_CH];
  logic [PW-1:0] wr_ptr_q [N_CH];
  logic [PW-1:0] wr_ptr_d [N_CH];

  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [CW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CW-1:0]     out_chan_q, out_chan_d;
  logic              mode_active_q, mode_active_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic              tick;
  logic [OW-1:0]     max_occ;
  logic [CW-1:0]     lat_idx;
  logic [CW-1:0]     rr_idx;
  logic              rr_found;
  int unsigned       rr_probe;
  logic              use_lat;
  logic              grant;
  logic [CW-1:0]     grant_idx;
  logic [N_CH-1:0]   push_acc;
  logic [N_CH-1:0]   pop;
  logic [31:0]       drop_sum;

  // Service tick divider: tick fires in the last cycle of each TICK_DIV window.
  always_comb begin
    tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  // Largest occupancy; strict compare keeps the lowest index on ties.
  always_comb begin
    max_occ = '0;
    lat_idx = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (occ_q[k] > max_occ) begin
        max_occ = occ_q[k];
        lat_idx = CW'(k);
      end
    end
  end

  // First non-empty channel strictly after the round-robin pointer, wrapping.
  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    rr_probe = 0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      rr_probe = (32'(rr_ptr_q) + i) % N_CH;
      if (!rr_found && (occ_q[rr_probe] != '0)) begin
        rr_found = 1'b1;
        rr_idx   = CW'(rr_probe);
      end
    end
  end

  // Mode resolution, grant decode and per-channel push acceptance.
  always_comb begin
    use_lat   = (mode_sel == 2'b00) || (mode_sel[1] && (32'(max_occ) >= THRESH));
    grant     = tick && (max_occ != '0);
    grant_idx = use_lat ? lat_idx : rr_idx;
    push_ready = '0;
    push_acc   = '0;
    pop        = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      push_ready[k] = (occ_q[k] != OW'(DEPTH));
      push_acc[k]   = push_valid[k] && push_ready[k];
      pop[k]        = grant && (grant_idx == CW'(k));
    end
  end

  // FIFO pointer/occupancy next state; pointers wrap at DEPTH, not a power of 2.
  always_comb begin
    for (int unsigned k = 0; k < N_CH; k++) begin
      occ_d[k]    = occ_q[k] + OW'(push_acc[k]) - OW'(pop[k]);
      rd_ptr_d[k] = rd_ptr_q[k];
      wr_ptr_d[k] = wr_ptr_q[k];
      if (pop[k]) begin
        rd_ptr_d[k] = (rd_ptr_q[k] == PW'(DEPTH - 1)) ? '0 : rd_ptr_q[k] + 1'b1;
      end
      if (push_acc[k]) begin
        wr_ptr_d[k] = (wr_ptr_q[k] == PW'(DEPTH - 1)) ? '0 : wr_ptr_q[k] + 1'b1;
      end
    end
  end

  // Output, arbitration state and saturating drop counter next state.
  always_comb begin
    out_valid_d   = grant;
    out_data_d    = out_data_q;
    out_chan_d    = out_chan_q;
    mode_active_d = mode_active_q;
    rr_ptr_d      = rr_ptr_q;
    if (grant) begin
      out_data_d    = mem_q[grant_idx][rd_ptr_q[grant_idx]];
      out_chan_d    = grant_idx;
      mode_active_d = ~use_lat;
      rr_ptr_d      = grant_idx;
    end
    drop_sum = 32'(drop_cnt_q);
    for (int unsigned k = 0; k < N_CH; k++) begin
      drop_sum = drop_sum + 32'(push_valid[k] && !push_ready[k]);
    end
    drop_cnt_d = (drop_sum > 32'd255) ? 8'hff : drop_sum[7:0];
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q    <= '0;
      rr_ptr_q      <= CW'(N_CH - 1);
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_chan_q    <= '0;
      mode_active_q <= 1'b0;
      drop_cnt_q    <= '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
        occ_q[k]    <= '0;
        rd_ptr_q[k] <= '0;
        wr_ptr_q[k] <= '0;
      end
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_chan_q    <= out_chan_d;
      mode_active_q <= mode_active_d;
      drop_cnt_q    <= drop_cnt_d;
      for (int unsigned k = 0; k < N_CH; k++) begin
        occ_q[k]    <= occ_d[k];
        rd_ptr_q[k] <= rd_ptr_d[k];
        wr_ptr_q[k] <= wr_ptr_d[k];
      end
    end
  end

  // Payload storage; contents are don't-care until pointed at, so no reset.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (push_acc[k] && !rst) begin
        mem_q[k][wr_ptr_q[k]] <= push_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Flatten per-channel occupancy onto the output bus.
  always_comb begin
    occupancy = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      occupancy[k*OW +: OW] = occ_q[k];
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_chan    = out_chan_q;
  assign mode_active = mode_active_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_multi_queue_scheduler.sv
// Directed bench: a default-rate instance and a slow-tick (64) instance share
// stimulus; each scenario task checks its own expected values.
module tb_multi_queue_scheduler;

  localparam int N_CH = 4;
  localparam int DW   = 2;
  localparam int CW   = 2;
  localparam int OW   = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N_CH-1:0]    push_valid = '0;
  logic [N_CH*DW-1:0] push_data = '0;
  logic [1:0]         mode_sel = 2'b00;

  logic [N_CH-1:0]    push_ready, s_push_ready;
  logic               out_valid, s_out_valid;
  logic [DW-1:0]      out_data, s_out_data;
  logic [CW-1:0]      out_chan, s_out_chan;
  logic               mode_active, s_mode_active;
  logic [N_CH*OW-1:0] occupancy, s_occupancy;
  logic [7:0]         drop_cnt, s_drop_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multi_queue_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .push_valid  (push_valid),
    .push_data   (push_data),
    .push_ready  (push_ready),
    .mode_sel    (mode_sel),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_chan    (out_chan),
    .mode_active (mode_active),
    .occupancy   (occupancy),
    .drop_cnt    (drop_cnt)
  );

  multi_queue_scheduler #(.TICK_DIV(64)) dut_slow (
    .clk         (clk),
    .rst         (rst),
    .push_valid  (push_valid),
    .push_data   (push_data),
    .push_ready  (s_push_ready),
    .mode_sel    (mode_sel),
    .out_valid   (s_out_valid),
    .out_data    (s_out_data),
    .out_chan    (s_out_chan),
    .mode_active (s_mode_active),
    .occupancy   (s_occupancy),
    .drop_cnt    (s_drop_cnt)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    push_valid = '0;
    cyc(1);
    rst = 1'b0;
  endtask

  // Returns cycles until out_valid of the chosen instance, or -1 on timeout.
  task automatic wait_out(input bit slow, input int maxc, output int n);
    bit seen = 1'b0;
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      if (!seen) begin
        cyc(1);
        if ((slow ? s_out_valid : out_valid) === 1'b1) begin
          seen = 1'b1;
          n = i;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    push_valid = '0;
    mode_sel = 2'b00;
    cyc(2);
    total++;
    if (occupancy !== '0) begin
      bad++; $display("FAIL reset_occ got=%h exp=0", occupancy);
    end
    total++;
    if (push_ready !== 4'b1111) begin
      bad++; $display("FAIL reset_ready got=%b exp=1111", push_ready);
    end
    total++;
    if ({out_valid, out_data, out_chan, mode_active, drop_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b d=%b c=%0d m=%b drop=%0d exp all 0",
               out_valid, out_data, out_chan, mode_active, drop_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    int n;
    int exp_n[4]      = '{1, 3, 4, 4};
    int exp_c[4]      = '{2, 2, 0, 2};
    logic [1:0] exp_d[4] = '{2'b01, 2'b10, 2'b01, 2'b11};
    mode_sel = 2'b00;
    do_reset();
    push_valid = 4'b0101; push_data = 8'b00_01_00_01; cyc(1);
    push_valid = 4'b0100; push_data = 8'b00_10_00_00; cyc(1);
    push_valid = 4'b0100; push_data = 8'b00_11_00_00; cyc(1);
    push_valid = '0;
    for (int j = 0; j < 4; j++) begin
      wait_out(1'b0, 10, n);
      total++;
      if (n !== exp_n[j] || out_chan !== CW'(exp_c[j]) || out_data !== exp_d[j]
          || mode_active !== 1'b0) begin
        bad++;
        $display("FAIL latency_%0d got n=%0d c=%0d d=%b m=%b exp n=%0d c=%0d d=%b m=0",
                 j, n, out_chan, out_data, mode_active, exp_n[j], exp_c[j], exp_d[j]);
      end
      if (j == 0) begin
        total++;
        if (occupancy !== 12'b000_010_000_001) begin
          bad++; $display("FAIL latency_occ got=%b exp=000010000001", occupancy);
        end
        cyc(1);
        total++;
        if (out_valid !== 1'b0 || out_chan !== 2'd2 || out_data !== 2'b01) begin
          bad++;
          $display("FAIL latency_pulse_hold got v=%b c=%0d d=%b exp v=0 c=2 d=01",
                   out_valid, out_chan, out_data);
        end
      end
    end
  endtask

  task automatic test_tie();
    int n;
    int exp_n[4]      = '{2, 4, 4, 4};
    int exp_c[4]      = '{1, 3, 1, 3};
    logic [1:0] exp_d[4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    mode_sel = 2'b00;
    do_reset();
    push_valid = 4'b1010; push_data = 8'b10_00_00_00; cyc(1);
    push_valid = 4'b1010; push_data = 8'b11_00_01_00; cyc(1);
    push_valid = '0;
    for (int j = 0; j < 4; j++) begin
      wait_out(1'b0, 10, n);
      total++;
      if (n !== exp_n[j] || out_chan !== CW'(exp_c[j]) || out_data !== exp_d[j]) begin
        bad++;
        $display("FAIL tie_%0d got n=%0d c=%0d d=%b exp n=%0d c=%0d d=%b",
                 j, n, out_chan, out_data, exp_n[j], exp_c[j], exp_d[j]);
      end
    end
  endtask

  task automatic test_round_robin();
    int n;
    mode_sel = 2'b01;
    do_reset();
    push_valid = 4'b1111; push_data = 8'b11_10_01_00; cyc(1);
    push_valid = '0;
    for (int j = 0; j < 4; j++) begin
      wait_out(1'b0, 10, n);
      total++;
      if (n !== ((j == 0) ? 3 : 4) || out_chan !== CW'(j) || out_data !== DW'(j)
          || mode_active !== 1'b1) begin
        bad++;
        $display("FAIL rr_%0d got n=%0d c=%0d d=%b m=%b exp n=%0d c=%0d d=%0d m=1",
                 j, n, out_chan, out_data, mode_active, (j == 0) ? 3 : 4, j, j);
      end
    end
    wait_out(1'b0, 12, n);
    total++;
    if (n !== -1 || mode_active !== 1'b1 || occupancy !== '0) begin
      bad++;
      $display("FAIL rr_empty got n=%0d m=%b occ=%h exp n=-1 m=1 occ=0",
               n, mode_active, occupancy);
    end
  endtask

  task automatic test_auto();
    int n;
    mode_sel = 2'b10;
    do_reset();
    push_valid = 4'b1010; push_data = 8'b11_00_01_00; cyc(1);
    push_valid = 4'b0010; push_data = 8'b00_00_10_00; cyc(1);
    push_valid = '0;
    wait_out(1'b0, 10, n);
    total++;
    if (n !== 2 || out_chan !== 2'd1 || out_data !== 2'b01 || mode_active !== 1'b1) begin
      bad++;
      $display("FAIL auto_rel got n=%0d c=%0d d=%b m=%b exp n=2 c=1 d=01 m=1",
               n, out_chan, out_data, mode_active);
    end
    push_valid = 4'b0100; push_data = 8'b00_00_00_00; cyc(1);
    push_data = 8'b00_01_00_00; cyc(1);
    push_data = 8'b00_10_00_00; cyc(1);
    push_valid = '0;
    wait_out(1'b0, 10, n);
    total++;
    if (n !== 1 || out_chan !== 2'd2 || out_data !== 2'b00 || mode_active !== 1'b0) begin
      bad++;
      $display("FAIL auto_lat got n=%0d c=%0d d=%b m=%b exp n=1 c=2 d=00 m=0",
               n, out_chan, out_data, mode_active);
    end
  endtask

  task automatic test_overflow();
    int n;
    int vals[8] = '{3, 1, 2, 0, 2, 3, 1, 1};
    mode_sel = 2'b00;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (s_push_ready[0] !== (i < 6)) begin
        bad++; $display("FAIL ovf_ready_%0d got=%b exp=%b", i, s_push_ready[0], i < 6);
      end
      push_valid = 4'b0001;
      push_data = {6'b0, 2'(vals[i])};
      cyc(1);
    end
    push_valid = '0;
    total++;
    if (s_drop_cnt !== 8'd2 || s_occupancy[OW-1:0] !== 3'd6) begin
      bad++;
      $display("FAIL ovf_drop got drop=%0d occ=%0d exp drop=2 occ=6",
               s_drop_cnt, s_occupancy[OW-1:0]);
    end
    for (int j = 0; j < 6; j++) begin
      wait_out(1'b1, 100, n);
      total++;
      if (n !== ((j == 0) ? 56 : 64) || s_out_data !== 2'(vals[j]) || s_out_chan !== 2'd0) begin
        bad++;
        $display("FAIL ovf_order_%0d got n=%0d d=%0d c=%0d exp n=%0d d=%0d c=0",
                 j, n, s_out_data, s_out_chan, (j == 0) ? 56 : 64, vals[j]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    mode_sel = 2'b00;
    do_reset();
    push_valid = 4'b0001;
    push_data = 8'b0000_0010;
    cyc(8);
    push_valid = '0;
    cyc(7);
    // Fast instance: one drop when full at a pop edge, four entries left, tick pending.
    total++;
    if (occupancy[OW-1:0] !== 3'd4 || drop_cnt !== 8'd1 || s_drop_cnt !== 8'd2) begin
      bad++;
      $display("FAIL mid_pre got occ=%0d drop=%0d sdrop=%0d exp occ=4 drop=1 sdrop=2",
               occupancy[OW-1:0], drop_cnt, s_drop_cnt);
    end
    rst = 1'b1;
    cyc(1);
    total++;
    if (out_valid !== 1'b0 || occupancy !== '0 || drop_cnt !== 8'd0 || s_drop_cnt !== 8'd0
        || s_occupancy !== '0 || push_ready !== 4'b1111) begin
      bad++;
      $display("FAIL mid_reset got v=%b occ=%h drop=%0d sdrop=%0d socc=%h rdy=%b exp 0/0/0/0/0/1111",
               out_valid, occupancy, drop_cnt, s_drop_cnt, s_occupancy, push_ready);
    end
    rst = 1'b0;
    push_valid = 4'b0001;
    push_data = 8'b0000_0011;
    cyc(1);
    push_valid = '0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL mid_after got v=%b exp=0", out_valid);
    end
    wait_out(1'b0, 10, n);
    total++;
    if (n !== 3 || out_data !== 2'b11 || out_chan !== 2'd0) begin
      bad++;
      $display("FAIL mid_first_tick got n=%0d d=%b c=%0d exp n=3 d=11 c=0",
               n, out_data, out_chan);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_tie();
    test_round_robin();
    test_auto();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
